// File: rtl/pulse_tx_checker.sv
// Pulse-train transmit checker.
// Drives a burst of N pulses into an external 4-bit counter, waits for the
// counter to settle, reads it back through a two-flop synchronizer and
// compares against the value predicted from the pre-burst readback.
//
// state        | meaning
// -------------+--------------------------------------------------------
// S_IDLE       | waiting for start; readback sampled as the burst base
// S_HIGH       | pulse_out high for HALF cycles
// S_LOW        | pulse_out low for HALF cycles; loop or finish the burst
// S_SETTLE     | SETTLE cycles for the external counter to settle
// S_CHECK      | one cycle; compare readback with expected, strobe done
module pulse_tx_checker #(
    parameter int HALF   = 4,
    parameter int SETTLE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] burst_len,
    input  logic [3:0] cnt_in,
    output logic       pulse_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] expected
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HIGH   = 3'd1;
    localparam logic [2:0] S_LOW    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;

    // Timer is a down-counter loaded with (length - 1); it only ever holds
    // values up to max(HALF, SETTLE) - 1.
    localparam int TMAX = (HALF > SETTLE) ? HALF : SETTLE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] HALF_LD   = TW'(HALF - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [3:0]    sync_q1;
    logic [3:0]    sync_cnt;
    logic [TW-1:0] tmr;
    logic          tmr_tc;
    logic [4:0]    remain;
    logic          accept;

    assign tmr_tc = (tmr == '0);
    assign busy   = (state != S_IDLE);
    assign accept = (state == S_IDLE) && start;

    // Next-state decode; start only counts when already sitting in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start)  state_nx = S_HIGH;
            S_HIGH:   if (tmr_tc) state_nx = S_LOW;
            S_LOW:    if (tmr_tc) state_nx = (remain != 5'd0) ? S_HIGH : S_SETTLE;
            S_SETTLE: if (tmr_tc) state_nx = S_CHECK;
            S_CHECK:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Two-flop synchronizer for the asynchronous counter readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 4'd0;
            sync_cnt <= 4'd0;
        end else begin
            sync_q1  <= cnt_in;
            sync_cnt <= sync_q1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Phase timer: reload on every state change, count down to terminal zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (state_nx != state) begin
            case (state_nx)
                S_HIGH, S_LOW: tmr <= HALF_LD;
                S_SETTLE:      tmr <= SETTLE_LD;
                default:       tmr <= '0;
            endcase
        end else if (!tmr_tc) begin
            tmr <= tmr - 1'b1;
        end
    end

    // Remaining pulse count; 5 bits so a burst_len of 0 can mean 16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= 5'd0;
        end else if (accept) begin
            remain <= (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
        end else if ((state == S_HIGH) && tmr_tc) begin
            remain <= remain - 5'd1;
        end
    end

    // Registered outputs: pulse follows HIGH, done/pass resolve on leaving CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_out <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            expected  <= 4'd0;
        end else begin
            pulse_out <= (state_nx == S_HIGH);
            done      <= (state == S_CHECK);
            if (accept) begin
                expected <= sync_cnt + burst_len;
                pass     <= 1'b0;
            end else if (state == S_CHECK) begin
                pass <= (sync_cnt == expected);
            end
        end
    end

endmodule

// File: tb/tb_pulse_tx_checker.sv
// Bench for pulse_tx_checker: an external-counter model driven by pulse_out,
// a cycle-count reference model of the outputs, directed scenarios and
// randomized bursts.
module tb_pulse_tx_checker;

    localparam int H = 4;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] burst_len = 4'd0;
    logic [3:0] cnt_in;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] expected;

    always #5 clk = ~clk;

    pulse_tx_checker #(.HALF(H), .SETTLE(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .burst_len (burst_len),
        .cnt_in    (cnt_in),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .expected  (expected)
    );

    // External counter: value = preset base + increments; one chosen rise may be dropped.
    logic [3:0] ext_base = 4'd0;
    logic [3:0] inc_cnt = 4'd0;
    int         rises_total = 0;
    int         drop_at = -1;
    assign cnt_in = ext_base + inc_cnt;

    always @(posedge pulse_out) begin
        rises_total <= rises_total + 1;
        if (rises_total + 1 != drop_at) inc_cnt <= inc_cnt + 4'd1;
    end

    // Reference model: t = cycles since the accepted start.
    bit         m_active = 1'b0;
    int         m_t = 0;
    int         m_n = 0;
    logic [3:0] m_exp = 4'd0;
    bit         m_pass = 1'b0;
    bit         m_done = 1'b0;
    logic [3:0] m_s1 = 4'd0;
    logic [3:0] m_s2 = 4'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_t <= 0; m_n <= 0; m_exp <= 4'd0;
            m_pass <= 1'b0; m_done <= 1'b0; m_s1 <= 4'd0; m_s2 <= 4'd0;
        end else begin
            m_s1   <= cnt_in;
            m_s2   <= m_s1;
            m_done <= 1'b0;
            if (m_active) begin
                m_t <= m_t + 1;
                if (m_t + 1 == 2 * H * m_n + S + 1) begin
                    m_pass   <= (m_s2 == m_exp);
                    m_done   <= 1'b1;
                    m_active <= 1'b0;
                end
            end else if (start) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_n      <= (burst_len == 4'd0) ? 16 : int'(burst_len);
                m_exp    <= m_s2 + burst_len;
                m_pass   <= 1'b0;
            end
        end
    end

    function automatic int m_pulse();
        return (m_active && (m_t < 2 * H * m_n) && ((m_t % (2 * H)) < H)) ? 1 : 0;
    endfunction

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("pulse_out", int'(pulse_out), m_pulse());
            chk("busy", int'(busy), int'(m_active));
            chk("done", int'(done), int'(m_done));
            chk("pass", int'(pass), int'(m_pass));
            chk("expected", int'(expected), int'(m_exp));
        end
    endtask

    task automatic set_cnt(input int v);
        @(negedge clk);
        ext_base = 4'(v) - inc_cnt;
        repeat (4) @(negedge clk);
    endtask

    // One burst; spam_t > 0 raises start for the cycle after edge spam_t.
    task automatic run_burst(input int bl, input int drop_nth, input int spam_t,
                             output int lat, output int rises, output int dones);
        int r0;
        @(negedge clk);
        burst_len = 4'(bl);
        start = 1'b1;
        r0 = rises_total;
        drop_at = (drop_nth > 0) ? r0 + drop_nth : -1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        dones = 0;
        while (lat < 400) begin
            @(posedge clk);
            lat++;
            #1 start = (lat == spam_t);
            @(negedge clk);
            if (done) begin
                dones++;
                break;
            end
        end
        start = 1'b0;
        if (lat >= 400) chk("done_timeout", lat, 0);
        rises = rises_total - r0;
    endtask

    task automatic stimulus();
        int lat, rises, dones, n, drop, spam, len;
        rst_n = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Plain burst of 5 from 0.
        set_cnt(0);
        run_burst(5, 0, 0, lat, rises, dones);
        chk("b5_latency", lat, 49);
        chk("b5_rises", rises, 5);
        chk("b5_expected", int'(expected), 5);
        chk("b5_pass", int'(pass), 1);
        @(negedge clk);
        chk("b5_done_width", int'(done), 0);

        // Wrap-around 14 + 3.
        set_cnt(14);
        run_burst(3, 0, 0, lat, rises, dones);
        chk("wrap_expected", int'(expected), 1);
        chk("wrap_pass", int'(pass), 1);

        // burst_len 0 means 16 pulses.
        set_cnt(9);
        run_burst(0, 0, 0, lat, rises, dones);
        chk("b16_latency", lat, 137);
        chk("b16_rises", rises, 16);
        chk("b16_expected", int'(expected), 9);
        chk("b16_pass", int'(pass), 1);

        // Counter misses the second pulse.
        set_cnt(0);
        run_burst(4, 2, 0, lat, rises, dones);
        chk("drop_cnt_in", int'(cnt_in), 3);
        chk("drop_expected", int'(expected), 4);
        chk("drop_pass", int'(pass), 0);
        @(negedge clk);
        chk("drop_done_width", int'(done), 0);

        // Second start during the third pulse.
        run_burst(6, 0, 17, lat, rises, dones);
        chk("spam_rises", rises, 6);
        chk("spam_dones", dones, 1);
        chk("spam_latency", lat, 57);

        // Start in the cycle CHECK returns to IDLE.
        run_burst(2, 0, 2 * H * 2 + S, lat, rises, dones);
        chk("chk_edge_latency", lat, 2 * H * 2 + S + 1);
        @(negedge clk);
        chk("chk_edge_busy", int'(busy), 0);

        // Reset during HIGH of the second pulse.
        @(negedge clk);
        burst_len = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_pulse", int'(pulse_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pulse", int'(pulse_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_burst(3, 0, 0, lat, rises, dones);
        chk("post_rst_latency", lat, 33);
        chk("post_rst_rises", rises, 3);
        chk("post_rst_pass", int'(pass), 1);

        // Randomized bursts.
        for (int i = 0; i < 15; i++) begin
            if ($urandom_range(0, 1) == 1) set_cnt($urandom_range(0, 15));
            len  = $urandom_range(0, 15);
            n    = (len == 0) ? 16 : len;
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            spam = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * H * n + S) : 0;
            run_burst(len, drop, spam, lat, rises, dones);
            chk("rnd_latency", lat, 2 * H * n + S + 1);
            chk("rnd_rises", rises, n);
            chk("rnd_dones", dones, 1);
            chk("rnd_pass", int'(pass), (drop == 0) ? 1 : 0);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pulse", int'(pulse_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass), 0);
        chk("reset_expected", int'(expected), 0);
        #2 rst_n = 1'b1;
        fork
            compare_loop();
            stimulus();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_tx_checker.md
PULSE_TX_CHECKER -- requirements
Module: pulse_tx_checker

Interface
REQ-001 The block SHALL have parameter HALF, default 4, giving the clock cycles pulse_out stays high and then low per pulse (HALF >= 1).
REQ-002 The block SHALL have parameter SETTLE, default 8, giving the clock cycles waited after the last pulse before readback (SETTLE >= 1).
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a burst; it is ignored unless the block is in IDLE.
REQ-006 The block SHALL have port burst_len, input, 4, the pulse count, sampled on an accepted start; 0 means 16 pulses.
REQ-007 The block SHALL have port cnt_in, input, 4, the asynchronous readback from the external 4-bit pulse counter.
REQ-008 The block SHALL have port pulse_out, output, 1, the pulse train driven to the external counter clock pin.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1, a one-cycle strobe when the check completes.
REQ-011 The block SHALL have port pass, output, 1, the result of the last check, held until the next accepted start.
REQ-012 The block SHALL have port expected, output, 4, the predicted counter value (base + pulses) mod 16 for the current or last burst.

Function
REQ-013 cnt_in SHALL pass through a two-flop synchronizer; all uses of the readback SHALL use the synchronized value (sync_cnt).
REQ-014 The FSM states SHALL be IDLE, HIGH, LOW, SETTLE_WAIT and CHECK.
REQ-015 In IDLE with start=1, the block SHALL latch base=sync_cnt and set the remaining count to burst_len (0 loaded as 16, using a 5-bit counter).
  - On the same edge it SHALL set expected=(sync_cnt+burst_len) mod 16, clear pass, and enter HIGH.
REQ-016 pulse_out SHALL be registered: 1 exactly while the FSM is in HIGH, 0 in all other states.
REQ-017 HIGH SHALL last exactly HALF cycles, then go to LOW and decrement the remaining count.
REQ-018 LOW SHALL last exactly HALF cycles, then go to HIGH if the remaining count is non-zero, else to SETTLE_WAIT.
REQ-019 Each pulse period SHALL therefore be 2*HALF cycles, giving exactly N rising edges on pulse_out per burst.
REQ-020 SETTLE_WAIT SHALL last exactly SETTLE cycles, then go to CHECK.
REQ-021 CHECK SHALL last one cycle, set pass=(sync_cnt==expected), pulse done=1 for that one cycle, and return to IDLE.
REQ-022 Arithmetic SHALL be modulo 16: base=14 with N=3 gives expected=1.
REQ-023 A start arriving while busy=1 SHALL be ignored with no effect on state, counters or outputs.
REQ-024 A start in the same cycle that CHECK returns to IDLE SHALL be ignored; start is accepted only when the FSM is already in IDLE.
REQ-025 Latency from accepted start to done SHALL be exactly 2*HALF*N + SETTLE + 1 cycles.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force: state=IDLE, pulse_out=0, busy=0, done=0, pass=0, expected=0, synchronizer flops=0, all counters=0.
REQ-027 Deassertion of rst_n in mid-burst SHALL resume only from IDLE, with no partial pulse or done emitted.
  - Any pulse already in progress SHALL be truncated low immediately on reset assertion.

Verification
REQ-028 HALF=4, SETTLE=8; model counter starting at 0 increments on each pulse_out rise; start, burst_len=5 -> 5 rising edges 8 cycles apart, done after 49 cycles, expected=5, pass=1.
REQ-029 Model counter at 14, burst_len=3 -> expected=1, pass=1 (wrap-around).
REQ-030 burst_len=0 -> exactly 16 pulses, expected=base, pass=1, done after 137 cycles.
REQ-031 Model counter drops the 2nd pulse, burst_len=4 from 0 -> cnt_in=3, expected=4, pass=0, done strobe still exactly one cycle.
REQ-032 Second start asserted during the 3rd pulse of a burst_len=6 burst -> ignored; exactly 6 pulses and one done.
REQ-033 rst_n pulled low during HIGH of the 2nd pulse -> pulse_out=0 and busy=0 at once, no done, and a new start after release runs a full burst normally.
